result_drain: RTL and testbench

Streams a block of result memory out of the SIMD processor after a program has run. The datapath writes `PE_COUNT`-lane result vectors into the result BRAM. This block is the reader side of that BRAM. On `start` it reads `count` consecutive words beginning at `base_addr` and serializes each word lane-by-lane onto a valid/ready stream toward the host. A small word buffer covers the BRAM read latency and downstream backpressure.

---
 rtl/result_drain.sv | 197 +++++++++++++++++++
 tb/tb_result_drain.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// rtl/result_drain.sv - drains a block of result BRAM as a lane-serialized valid/ready stream
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   start, base_addr, count   drain request, base and count captured in IDLE
//   busy, done                drain in progress, one-cycle completion pulse
//   bram_en, bram_addr        result BRAM read port (registered)
//   bram_rdata                BRAM read data, valid the cycle after bram_en
//   m_data, m_valid, m_ready  lane stream toward the host
//   m_last                    final lane of the final word
module result_drain #(
    parameter int PE_COUNT   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BRAM_DEPTH = 1024,
    parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            count,
    output logic                           busy,
    output logic                           done,
    output logic                           bram_en,
    output logic [ADDR_WIDTH-1:0]          bram_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_rdata,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_last
);

    localparam int LANE_W = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
    localparam int WORD_W = PE_COUNT * DATA_WIDTH;
    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(PE_COUNT - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(BRAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = ADDR_WIDTH'(BRAM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  rd_addr;      // next address to issue
    logic [ADDR_WIDTH:0]    reads_left;   // reads not yet issued
    logic [ADDR_WIDTH:0]    words_left;   // words not yet popped (head included)
    logic                   rd_valid;     // bram_rdata holds a requested word this cycle

    logic [WORD_W-1:0]      mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             fifo_cnt;
    logic [LANE_W-1:0]      lane;

    logic                   hs;
    logic                   pop;
    logic                   push;
    logic [1:0]             fifo_cnt_n;
    logic [1:0]             fifo_after_pop;
    logic                   rd_ptr_n;
    logic [LANE_W-1:0]      lane_n;
    logic [ADDR_WIDTH:0]    words_left_n;
    logic [WORD_W-1:0]      head_n;
    logic [DATA_WIDTH-1:0]  data_n;
    logic [2:0]             occ;
    logic                   issue;
    logic [ADDR_WIDTH:0]    cnt_c;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == TOP_ADDR) ? '0 : a + 1'b1;
    endfunction

    always_comb begin
        hs             = m_valid && m_ready;
        pop            = hs && (lane == LAST_LANE);
        push           = rd_valid;
        fifo_after_pop = fifo_cnt - {1'b0, pop};
        fifo_cnt_n     = fifo_after_pop + {1'b0, push};
        rd_ptr_n       = rd_ptr ^ pop;
        words_left_n   = words_left - (ADDR_WIDTH + 1)'(pop);

        lane_n = lane;
        if (pop) begin
            lane_n = '0;
        end else if (hs) begin
            lane_n = lane + 1'b1;
        end

        // The next head is the word arriving now only when nothing else is left queued.
        if (push && (fifo_after_pop == 2'd0)) begin
            head_n = bram_rdata;
        end else begin
            head_n = mem[rd_ptr_n];
        end

        data_n = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            if (lane_n == LANE_W'(i)) begin
                data_n = head_n[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Buffered + arriving + currently requested words, with a word popped now counted as free.
        occ   = {1'b0, fifo_cnt} + {2'b0, rd_valid} + {2'b0, bram_en} - {2'b0, pop};
        issue = (state == S_RUN) && (reads_left != '0) && (occ < 3'd2);

        cnt_c = (count > DEPTH_CNT) ? DEPTH_CNT : count;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            rd_addr    <= '0;
            reads_left <= '0;
            words_left <= '0;
            rd_valid   <= 1'b0;
            mem[0]     <= '0;
            mem[1]     <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= '0;
            lane       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bram_en    <= 1'b0;
            bram_addr  <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
        end else begin
            rd_valid <= bram_en;

            if (push) begin
                mem[wr_ptr] <= bram_rdata;
                wr_ptr      <= ~wr_ptr;
            end
            rd_ptr     <= rd_ptr_n;
            fifo_cnt   <= fifo_cnt_n;
            lane       <= lane_n;
            words_left <= words_left_n;

            m_valid <= (fifo_cnt_n != 2'd0);
            m_data  <= data_n;
            m_last  <= (fifo_cnt_n != 2'd0) && (lane_n == LAST_LANE)
                       && (words_left_n == (ADDR_WIDTH + 1)'(1));

            case (state)
                S_IDLE: begin
                    bram_en <= 1'b0;
                    done    <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (cnt_c == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            // First read goes out immediately so data lands two edges later.
                            state      <= S_RUN;
                            bram_en    <= 1'b1;
                            bram_addr  <= base_addr;
                            rd_addr    <= next_addr(base_addr);
                            reads_left <= cnt_c - 1'b1;
                            words_left <= cnt_c;
                        end
                    end
                end
                S_RUN: begin
                    bram_en <= issue;
                    if (issue) begin
                        bram_addr  <= rd_addr;
                        rd_addr    <= next_addr(rd_addr);
                        reads_left <= reads_left - 1'b1;
                    end
                    if (hs && m_last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    bram_en <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    bram_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// tb/tb_result_drain.sv - scoreboard bench for result_drain
module tb_result_drain;
    localparam int PE    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW:0]       count = '0;
    logic              busy, done, bram_en;
    logic [AW-1:0]     bram_addr;
    logic [PE*DW-1:0]  bram_rdata = '0;
    logic [DW-1:0]     m_data;
    logic              m_valid, m_last;
    logic              m_ready = 1'b1;

    int checks = 0, errors = 0;
    int cyc = 0;
    int issued = 0, popped = 0, beats = 0, lane_ct = 0, valid_seen = 0, done_cnt = 0, en_total = 0;
    int first_en = -1, first_valid = -1, last_hs = -1, done_cyc = -1;
    bit bp_mode = 1'b0;
    logic prev_stall = 1'b0, prev_last = 1'b0, prev_done = 1'b0;
    logic [DW-1:0] prev_data = '0;

    logic [DW-1:0] exp_data[$];
    bit            exp_last[$];
    int            exp_addr[$];

    result_drain #(.PE_COUNT(PE), .DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_rdata(bram_rdata), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PE*DW-1:0] word(input int a);
        logic [PE*DW-1:0] w;
        for (int l = 0; l < PE; l++) w[l*DW +: DW] = DW'(PE * a + l);
        return w;
    endfunction

    always @(posedge clk) if (bram_en) bram_rdata <= word(int'(bram_addr));

    always @(posedge clk) begin
        #1;
        if (bp_mode) m_ready = 1'($urandom_range(0, 1));
        else         m_ready = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (bram_en) begin
                issued++;
                en_total++;
                if (first_en < 0) first_en = cyc;
                check("occupancy_le_2", 64'(issued - popped <= 2), 64'd1);
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_read: got addr %0d expected no read", bram_addr);
                end else begin
                    check("bram_addr", 64'(bram_addr), 64'(exp_addr.pop_front()));
                end
            end
            if (m_valid) begin
                valid_seen++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (prev_stall)
                check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
            if (m_valid && m_ready) begin
                beats++;
                if (exp_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_beat: got data %0d expected no beat", m_data);
                end else begin
                    check("m_data", 64'(m_data), 64'(exp_data.pop_front()));
                    check("m_last", 64'(m_last), 64'(exp_last.pop_front()));
                end
                if (m_last) last_hs = cyc;
                lane_ct++;
                if (lane_ct == PE) begin
                    lane_ct = 0;
                    popped++;
                end
            end else if (!m_valid) begin
                check("m_last_idle", 64'(m_last), 64'd0);
            end
            if (prev_done) check("busy_fall", 64'(busy), 64'd0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_in_done", 64'(busy), 64'd1);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            prev_done  = done;
        end else begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            lane_ct    = 0;
            issued     = 0;
            popped     = 0;
        end
    end

    task automatic push_exp(input int base, input int cnt);
        int eff;
        int a;
        eff = (cnt > DEPTH) ? DEPTH : cnt;
        for (int w = 0; w < eff; w++) begin
            a = (base + w) % DEPTH;
            exp_addr.push_back(a);
            for (int l = 0; l < PE; l++) begin
                exp_data.push_back(DW'(PE * a + l));
                exp_last.push_back((w == eff - 1) && (l == PE - 1));
            end
        end
    endtask

    task automatic pulse_start(input int base, input int cnt, output int s);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(base); count = (AW + 1)'(cnt);
        @(posedge clk); #1;
        s = cyc;
        start = 1'b0;
    endtask

    task automatic drain(input int base, input int cnt, input bit timing, input int intr_base);
        int eff, s, n, d0, dummy;
        eff = (cnt > DEPTH) ? DEPTH : cnt;
        push_exp(base, cnt);
        first_en = -1; first_valid = -1; last_hs = -1;
        d0 = done_cnt;
        pulse_start(base, cnt, s);
        if (intr_base >= 0) begin
            repeat (5) @(posedge clk);
            check("busy_mid", 64'(busy), 64'd1);
            pulse_start(intr_base, 2, dummy);
        end
        n = 0;
        while (done_cnt == d0 && n < 20 * eff + 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done_cnt != d0), 64'd1);
        if (timing) begin
            check("first_en_cycle", 64'(first_en - s), 64'd0);
            check("first_valid_cycle", 64'(first_valid - s), 64'd2);
            check("done_after_last", 64'(done_cyc - last_hs), 64'd1);
        end
        if (eff == 0) check("zero_done_cycle", 64'(done_cyc - s), 64'd0);
        @(negedge clk); @(negedge clk);
        check("beats_pending", 64'(exp_data.size()), 64'd0);
        check("reads_pending", 64'(exp_addr.size()), 64'd0);
    endtask

    initial begin
        int e0, v0, b0, d0, s, n;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy, done, bram_en, bram_addr, m_valid, m_last, m_data}), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_outputs", 64'({busy, done, bram_en, m_valid, m_last}), 64'd0);

        drain(10, 3, 1'b1, -1);

        bp_mode = 1'b1;
        drain(10, 3, 1'b0, -1);
        drain(7, 5, 1'b0, -1);
        bp_mode = 1'b0;

        drain(1022, 4, 1'b0, -1);

        e0 = en_total; v0 = valid_seen;
        drain(0, 0, 1'b0, -1);
        check("zero_no_en", 64'(en_total - e0), 64'd0);
        check("zero_no_valid", 64'(valid_seen - v0), 64'd0);

        b0 = beats;
        drain(5, 2000, 1'b0, -1);
        check("oversize_beats", 64'(beats - b0), 64'(DEPTH * PE));

        drain(100, 3, 1'b0, 500);

        b0 = beats; d0 = done_cnt;
        push_exp(0, 8);
        pulse_start(0, 8, s);
        n = 0;
        while (beats < b0 + 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("five_beats_seen", 64'(beats >= b0 + 5), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("reset_mid_outputs", 64'({busy, done, bram_en, bram_addr, m_valid, m_last, m_data}), 64'd0);
        exp_data.delete(); exp_last.delete(); exp_addr.delete();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        check("idle_after_reset", 64'({busy, m_valid}), 64'd0);

        b0 = beats;
        drain(0, 1, 1'b0, -1);
        check("post_reset_beats", 64'(beats - b0), 64'(PE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
